// File: rtl/tailights_input_cond.sv
// Input conditioner for the taillight sequencer: synchronizes, debounces and
// arbitrates the lever/hazard switches, and generates the pattern step tick.
module tailights_input_cond #(
  parameter int DB_CYCLES = 4,
  parameter int TICK_DIV  = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic left_sw,
  input  logic right_sw,
  input  logic hazard_sw,
  output logic L,
  output logic R,
  output logic H,
  output logic tick
);

  localparam int CW = $clog2(DB_CYCLES) + 1;
  localparam int TW = $clog2(TICK_DIV);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LEFT,
    ST_RIGHT,
    ST_HAZ
  } state_t;

  // Bit 0 = left, bit 1 = right, bit 2 = hazard.
  logic [2:0]    raw;
  logic [2:0]    sync1_q, sync2_q;
  logic [2:0]    deb_q, deb_d;
  logic [CW-1:0] db_cnt_q [3];
  logic [CW-1:0] db_cnt_d [3];

  state_t        state_q, state_d, target;
  logic          state_chg;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          tick_q, tick_d;
  logic          l_q, r_q, h_q;

  assign raw = {hazard_sw, right_sw, left_sw};

  // NOTE: every assignment in always_comb gets a default first, so no path
  // through the block can leave a variable unassigned and infer a latch.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      deb_d[i]    = deb_q[i];
      db_cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (db_cnt_q[i] == CW'(DB_CYCLES - 1)) begin
          deb_d[i] = sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + CW'(1);
        end
      end
    end
  end

  always_comb begin
    target = ST_IDLE;
    if (deb_q[2] || (deb_q[0] && deb_q[1])) begin
      target = ST_HAZ;
    end else if (deb_q[0]) begin
      target = ST_LEFT;
    end else if (deb_q[1]) begin
      target = ST_RIGHT;
    end

    // A direct left<->right swap passes through one all-low cycle so the
    // sequencer restarts its pattern.
    state_d = target;
    if ((state_q == ST_LEFT && target == ST_RIGHT) ||
        (state_q == ST_RIGHT && target == ST_LEFT)) begin
      state_d = ST_IDLE;
    end
    state_chg = (state_d != state_q);

    tcnt_d = '0;
    tick_d = 1'b0;
    if (!state_chg) begin
      if (tcnt_q == TW'(TICK_DIV - 1)) begin
        tick_d = 1'b1;
      end else begin
        tcnt_d = tcnt_q + TW'(1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      deb_q   <= '0;
      // NOTE: the debounce counters are a tiny register array, not a memory,
      // so resetting them costs nothing and keeps glitch filtering exact.
      for (int i = 0; i < 3; i++) db_cnt_q[i] <= '0;
      state_q <= ST_IDLE;
      tcnt_q  <= '0;
      tick_q  <= 1'b0;
      l_q     <= 1'b0;
      r_q     <= 1'b0;
      h_q     <= 1'b0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      for (int i = 0; i < 3; i++) db_cnt_q[i] <= db_cnt_d[i];
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      tick_q  <= tick_d;
      l_q     <= (state_d == ST_LEFT);
      r_q     <= (state_d == ST_RIGHT);
      h_q     <= (state_d == ST_HAZ);
    end
  end

  assign L    = l_q;
  assign R    = r_q;
  assign H    = h_q;
  assign tick = tick_q;

endmodule

// File: tb/tb_tailights_input_cond.sv
// Bench for tailights_input_cond: directed scenarios plus random switch
// activity, compared cycle by cycle against a behavioural model.
module tb_tailights_input_cond;

  localparam int DB = 4;
  localparam int TD = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic left_sw = 1'b0, right_sw = 1'b0, hazard_sw = 1'b0;
  logic L, R, H, tick;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;

  // Behavioural model: modes 0 none, 1 left, 2 right, 3 hazard.
  bit       m_s1 [3];
  bit       m_s2 [3];
  bit       m_d  [3];
  int       m_run[3];
  int       m_mode;
  int       m_since;
  logic [3:0] exp_vec;

  tailights_input_cond #(.DB_CYCLES(DB), .TICK_DIV(TD)) dut (
    .clk(clk), .rst(rst), .left_sw(left_sw), .right_sw(right_sw),
    .hazard_sw(hazard_sw), .L(L), .R(R), .H(H), .tick(tick)
  );

  always #5 clk = ~clk;

  // Advance one clock edge, update the model, return at the falling edge.
  task automatic step();
    bit raw [3];
    int tgt;
    bit changed;
    @(posedge clk);
    cyc++;
    raw[0] = left_sw; raw[1] = right_sw; raw[2] = hazard_sw;
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        m_s1[i] = 0; m_s2[i] = 0; m_d[i] = 0; m_run[i] = 0;
      end
      m_mode  = 0;
      m_since = 0;
      exp_vec = 4'b0000;
    end else begin
      if (m_d[2] || (m_d[0] && m_d[1])) tgt = 3;
      else if (m_d[0]) tgt = 1;
      else if (m_d[1]) tgt = 2;
      else tgt = 0;
      if ((m_mode == 1 && tgt == 2) || (m_mode == 2 && tgt == 1)) tgt = 0;
      changed = (tgt != m_mode);
      m_mode  = tgt;
      m_since = changed ? 0 : m_since + 1;
      for (int i = 0; i < 3; i++) begin
        if (m_s2[i] != m_d[i]) begin
          m_run[i]++;
          if (m_run[i] == DB) begin
            m_d[i]   = m_s2[i];
            m_run[i] = 0;
          end
        end else begin
          m_run[i] = 0;
        end
        m_s2[i] = m_s1[i];
        m_s1[i] = raw[i];
      end
      exp_vec = {m_mode == 1, m_mode == 2, m_mode == 3,
                 (m_since > 0) && (m_since % TD == 0)};
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    int first_tick = -1;
    rst = 1'b1; left_sw = 0; right_sw = 0; hazard_sw = 0;
    for (int k = 0; k < 2; k++) begin
      step();
      n_cmp++;
      if ({L, R, H, tick} !== 4'b0000) begin
        n_fail++;
        $display("FAIL reset_outputs cyc=%0d got LRHt=%b need 0000", cyc, {L, R, H, tick});
      end
    end
    rst = 1'b0;
    for (int k = 1; k <= 24; k++) begin
      step();
      n_cmp++;
      if ({L, R, H, tick} !== exp_vec) begin
        n_fail++;
        $display("FAIL idle_tick cyc=%0d got LRHt=%b need %b", cyc, {L, R, H, tick}, exp_vec);
      end
      if (tick === 1'b1 && first_tick < 0) first_tick = k;
    end
    n_cmp++;
    if (first_tick != TD) begin
      n_fail++;
      $display("FAIL first_tick_after_reset got %0d cycles need %0d", first_tick, TD);
    end
  endtask

  task automatic test_left();
    int lat = -1;
    int tk = -1;
    left_sw = 1'b1;
    for (int k = 1; k <= 20 && lat < 0; k++) begin
      step();
      n_cmp++;
      if ({L, R, H, tick} !== exp_vec) begin
        n_fail++;
        $display("FAIL left_rise cyc=%0d got LRHt=%b need %b", cyc, {L, R, H, tick}, exp_vec);
      end
      if (L === 1'b1) lat = k;
    end
    n_cmp++;
    if (lat != DB + 3) begin
      n_fail++;
      $display("FAIL left_latency got %0d edges need %0d", lat, DB + 3);
    end
    for (int k = 1; k <= 20; k++) begin
      step();
      n_cmp++;
      if ({L, R, H, tick} !== exp_vec) begin
        n_fail++;
        $display("FAIL left_steady cyc=%0d got LRHt=%b need %b", cyc, {L, R, H, tick}, exp_vec);
      end
      if (tick === 1'b1 && tk < 0) tk = k;
    end
    n_cmp++;
    if (tk != TD) begin
      n_fail++;
      $display("FAIL left_first_tick got %0d cycles need %0d", tk, TD);
    end
  endtask

  task automatic test_glitch();
    int l_drop = 0;
    for (int k = 0; k < 24; k++) begin
      left_sw = (k >= 2 && k < 5) ? 1'b0 : 1'b1;
      step();
      n_cmp++;
      if ({L, R, H, tick} !== exp_vec) begin
        n_fail++;
        $display("FAIL glitch cyc=%0d got LRHt=%b need %b", cyc, {L, R, H, tick}, exp_vec);
      end
      if (L !== 1'b1) l_drop++;
    end
    n_cmp++;
    if (l_drop != 0) begin
      n_fail++;
      $display("FAIL glitch_hold got %0d low cycles of L need 0", l_drop);
    end
  endtask

  task automatic test_left_to_right();
    int phase = 0;  // 0: L high, 1: all low seen, 2: R high
    int gap = 0;
    left_sw = 1'b0; right_sw = 1'b1;
    for (int k = 0; k < 30; k++) begin
      step();
      n_cmp++;
      if ({L, R, H, tick} !== exp_vec) begin
        n_fail++;
        $display("FAIL swap cyc=%0d got LRHt=%b need %b", cyc, {L, R, H, tick}, exp_vec);
      end
      if (phase == 0 && {L, R, H} == 3'b000) phase = 1;
      if (phase == 1 && {L, R, H} == 3'b000) gap++;
      if (phase == 1 && R === 1'b1) phase = 2;
    end
    n_cmp++;
    if (phase != 2 || gap != 1) begin
      n_fail++;
      $display("FAIL swap_gap got phase=%0d gap=%0d need phase=2 gap=1", phase, gap);
    end
  endtask

  task automatic test_hazard();
    int both = 0;
    right_sw = 1'b0; left_sw = 1'b1;
    for (int k = 0; k < 24; k++) step();
    hazard_sw = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step();
      n_cmp++;
      if ({L, R, H, tick} !== exp_vec) begin
        n_fail++;
        $display("FAIL hazard_on cyc=%0d got LRHt=%b need %b", cyc, {L, R, H, tick}, exp_vec);
      end
      if (L === 1'b1 && H === 1'b1) both++;
    end
    n_cmp++;
    if (both != 0 || H !== 1'b1) begin
      n_fail++;
      $display("FAIL hazard_excl got overlap=%0d H=%b need overlap=0 H=1", both, H);
    end
    hazard_sw = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step();
      n_cmp++;
      if ({L, R, H, tick} !== exp_vec) begin
        n_fail++;
        $display("FAIL hazard_off cyc=%0d got LRHt=%b need %b", cyc, {L, R, H, tick}, exp_vec);
      end
      if ({L, R, H} == 3'b000) both++;
    end
    n_cmp++;
    if (both != 0 || L !== 1'b1) begin
      n_fail++;
      $display("FAIL hazard_to_left got idle_cycles=%0d L=%b need 0 and 1", both, L);
    end
  endtask

  task automatic test_reset_mid();
    int found = 0;
    int lat = -1;
    hazard_sw = 1'b1;
    for (int k = 0; k < 60 && !found; k++) begin
      step();
      if (H === 1'b1 && m_mode == 3 && m_since % TD == 5) found = 1;
    end
    n_cmp++;
    if (!found) begin
      n_fail++;
      $display("FAIL reset_mid_setup got no H with phase 5 need one within 60 cycles");
    end
    rst = 1'b1;
    step();
    n_cmp++;
    if ({L, R, H, tick} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_mid cyc=%0d got LRHt=%b need 0000", cyc, {L, R, H, tick});
    end
    rst = 1'b0;
    for (int k = 1; k <= 20 && lat < 0; k++) begin
      step();
      n_cmp++;
      if ({L, R, H, tick} !== exp_vec) begin
        n_fail++;
        $display("FAIL reset_mid_recover cyc=%0d got LRHt=%b need %b", cyc, {L, R, H, tick}, exp_vec);
      end
      if (H === 1'b1) lat = k;
    end
    n_cmp++;
    if (lat != DB + 3) begin
      n_fail++;
      $display("FAIL reset_mid_latency got %0d edges need %0d", lat, DB + 3);
    end
  endtask

  task automatic test_random();
    int hold = 0;
    for (int k = 0; k < 3000; k++) begin
      if (hold == 0) begin
        left_sw   = 1'($urandom_range(0, 1));
        right_sw  = 1'($urandom_range(0, 1));
        hazard_sw = ($urandom_range(0, 3) == 0);
        hold = (($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : $urandom_range(5, 30));
      end
      hold--;
      rst = ($urandom_range(0, 499) == 0);
      step();
      n_cmp++;
      if ({L, R, H, tick} !== exp_vec) begin
        n_fail++;
        $display("FAIL random cyc=%0d got LRHt=%b need %b", cyc, {L, R, H, tick}, exp_vec);
      end
      n_cmp++;
      if ($countones({L, R, H}) > 1) begin
        n_fail++;
        $display("FAIL onehot cyc=%0d got LRH=%b need at most one high", cyc, {L, R, H});
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_left();
    test_glitch();
    test_left_to_right();
    test_hazard();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/tailights_input_cond.md
Name: tailights_input_cond

Overview:
- Upstream conditioner for the taillight sequencer `tailights_bh`.
- Takes raw, asynchronous lever and hazard switches and synchronizes, debounces and arbitrates them.
- Drives clean, mutually exclusive L/R/H requests plus a divided step-enable tick, which the sequencer consumes directly.

Parameters:
DB_CYCLES, 4, consecutive cycles a synchronized input must differ from its debounced value before the debounced value updates (>=1)
TICK_DIV, 8, step-tick period in clk cycles (>=2)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
left_sw  input  1  raw left-turn lever, asynchronous
right_sw  input  1  raw right-turn lever, asynchronous
hazard_sw  input  1  raw hazard switch, asynchronous
L  output  1  conditioned left request, registered
R  output  1  conditioned right request, registered
H  output  1  conditioned hazard request, registered
tick  output  1  one-cycle step enable for the sequencer, registered

Behaviour:
- Reset (rst=1 at an edge):
  - All synchronizer flops, debounced values and debounce counters go to 0.
  - State goes to IDLE and the tick counter goes to 0.
  - L=R=H=tick=0 after that edge.
  - Reset mid-operation behaves identically; it overrides every other event in the same cycle.
- Synchronizer: a 2-flop chain per input. The synchronized value s_x is valid 2 edges after the raw change.
- Debounce, per input, with counter width clog2(DB_CYCLES)+1:
  - Each edge where s_x != d_x: counter increments. When counter == DB_CYCLES-1, d_x <= s_x and counter <= 0 on that edge.
  - Any edge where s_x == d_x: counter <= 0, so a glitch shorter than DB_CYCLES cycles never reaches d_x.
- Arbitration FSM on (dl, dr, dh), with states IDLE, LEFT, RIGHT, HAZ. Next state by priority:
  - dh=1, or dl=1 and dr=1 -> HAZ.
  - Else dl=1 -> LEFT.
  - Else dr=1 -> RIGHT.
  - Else -> IDLE.
  - Exception: from LEFT to RIGHT or RIGHT to LEFT, the FSM goes to IDLE for exactly one cycle, then to the target if the target is still requested. This guarantees the sequencer sees all requests low and restarts its pattern.
  - HAZ -> LEFT/RIGHT transitions go direct.
- Outputs: L=(state==LEFT), R=(state==RIGHT), H=(state==HAZ).
  - At most one output is high in any cycle.
  - All three are low in IDLE.
- End-to-end latency from the first edge sampling a stable raw change to the output change is DB_CYCLES+3 edges: 2 sync, DB_CYCLES debounce, 1 FSM.
- Tick counter runs 0..TICK_DIV-1 and wraps to 0.
  - tick=1 on the cycle after the counter holds TICK_DIV-1 (registered compare), otherwise 0.
  - Whenever the FSM state changes, the counter is forced to 0 on that same edge and tick is forced to 0. The first tick of a new pattern therefore arrives a full TICK_DIV cycles after the state change.
  - The counter runs in all states, including IDLE.
- Simultaneous events:
  - A state change and a counter wrap on the same edge: the reset to 0 wins and tick stays 0.
  - Raw left and right rising together: debounce to HAZ if both settle on the same edge. Otherwise the first to settle wins briefly, then HAZ once both are 1.

Test Plan:
1. rst=1 for 2 cycles, all switches 0 -> L=R=H=tick=0. After release, tick pulses every 8 cycles, first pulse 8 cycles after rst falls.
2. left_sw 0->1 held -> L=1 exactly 7 edges later (DB_CYCLES+3), R=H=0. First tick exactly 8 cycles after L rises, then every 8 cycles.
3. left_sw=1 with a 3-cycle 0-glitch after L=1 -> L stays 1 throughout, with no state change and no tick-phase reset.
4. L=1 steady, then left_sw 1->0 and right_sw 0->1 on the same cycle -> L falls, one IDLE cycle with L=R=H=0, then R=1. Tick counter restarts at each state change.
5. L=1 steady, hazard_sw 0->1 -> after 7 edges H=1 and L=0 on the same edge, never L=H=1 together. hazard_sw 1->0 with left_sw still 1 -> returns directly to L=1.
6. H=1 with the tick counter at 5, rst=1 for one edge -> next cycle L=R=H=tick=0. After release with hazard_sw still 1, H=1 again 7 edges later.
